// File: rtl/controle_robo_if.sv
// controle_robo_if: sensor inputs and motor/status outputs of the wall-following controller
interface controle_robo_if;
  logic habilita, head, left, under, barreira;
  logic avancar, girar, remover, falha;
  logic [2:0] estado;
  modport master (
    output habilita, head, left, under, barreira,
    input  avancar, girar, remover, estado, falha
  );
  modport slave (
    input  habilita, head, left, under, barreira,
    output avancar, girar, remover, estado, falha
  );
endinterface

// File: rtl/controle_robo.sv
// controle_robo: debounced-sensor wall-following FSM with timed turns, bounded removal retries and sticky fault
module controle_robo #(
  parameter int DEB_CYCLES    = 4,
  parameter int TURN_CYCLES   = 16,
  parameter int REMOVE_CYCLES = 8,
  parameter int SEARCH_MAX    = 1024,
  parameter int MAX_RETRY     = 2
) (
  input logic c1,
  input logic reset,
  controle_robo_if.slave bus
);
  localparam logic [2:0] STANDBY = 3'b111, PROCURA = 3'b000, ACOMPANHA = 3'b010,
                         REMOVE = 3'b011, GIRA = 3'b100;
  localparam int CMAX = TURN_CYCLES > REMOVE_CYCLES ? TURN_CYCLES : REMOVE_CYCLES;
  localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int SW = SEARCH_MAX > 1 ? $clog2(SEARCH_MAX) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [DW-1:0] D_END = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] T_END = CW'(TURN_CYCLES - 1), R_END = CW'(REMOVE_CYCLES - 1);
  localparam logic [SW-1:0] S_END = SW'(SEARCH_MAX - 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);

  logic [4:0] raw, s1, s2;
  logic [3:0] flt;
  logic hab, hd, lf, un, br;
  logic [2:0] st, nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scnt;
  logic [RW-1:0] rty;
  logic rst_cnt, set_f, falha, avancar, girar, remover;

  assign raw = {bus.habilita, bus.barreira, bus.under, bus.left, bus.head};
  assign {hab, br, un, lf, hd} = {s2[4], flt[3], flt[2], flt[1], flt[0]};

  always_ff @(posedge c1 or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end

  genvar i;
  for (i = 0; i < 4; i++) begin : g_deb
    logic [DW-1:0] dc;
    logic f;
    always_ff @(posedge c1 or negedge reset)
      if (!reset) begin
        dc <= '0;
        f  <= 1'b0;
      end else if (s2[i] == f) dc <= '0;
      else if (dc == D_END) begin
        f  <= s2[i];
        dc <= '0;
      end else dc <= dc + 1'b1;
    assign flt[i] = f;
  end

  // rst_cnt marks a turn or removal attempt restarting without leaving its state
  always_comb begin
    nxt     = st;
    rst_cnt = 1'b0;
    set_f   = 1'b0;
    if (!hab || un) nxt = STANDBY;
    else case (st)
      STANDBY:   nxt = falha ? STANDBY : PROCURA;
      PROCURA:   nxt = br ? REMOVE : hd ? GIRA : lf ? ACOMPANHA : scnt == S_END ? GIRA : PROCURA;
      ACOMPANHA: nxt = br ? REMOVE : hd ? GIRA : lf ? ACOMPANHA : PROCURA;
      GIRA: if (cnt == T_END) begin
        nxt     = hd ? GIRA : lf ? ACOMPANHA : PROCURA;
        rst_cnt = hd;
      end
      REMOVE: if (cnt == R_END) begin
        nxt     = !br ? (lf ? ACOMPANHA : PROCURA) : rty < R_MAX ? REMOVE : STANDBY;
        rst_cnt = br && rty < R_MAX;
        set_f   = br && !(rty < R_MAX);
      end
      default:   nxt = STANDBY;
    endcase
  end

  always_ff @(posedge c1 or negedge reset)
    if (!reset) begin
      st      <= STANDBY;
      cnt     <= '0;
      scnt    <= '0;
      rty     <= '0;
      falha   <= 1'b0;
      avancar <= 1'b0;
      girar   <= 1'b0;
      remover <= 1'b0;
    end else begin
      st      <= nxt;
      cnt     <= (nxt != st || rst_cnt) ? '0 : cnt + 1'b1;
      scnt    <= (st == PROCURA && nxt == PROCURA) ? scnt + 1'b1 : '0;
      rty     <= st != REMOVE ? '0 : rst_cnt ? rty + 1'b1 : rty;
      falha   <= !hab ? 1'b0 : (falha | set_f);
      avancar <= nxt == PROCURA || nxt == ACOMPANHA;
      girar   <= nxt == GIRA;
      remover <= nxt == REMOVE;
    end

  assign bus.estado  = st;
  assign bus.falha   = falha;
  assign bus.avancar = avancar;
  assign bus.girar   = girar;
  assign bus.remover = remover;
endmodule

// File: tb/tb_controle_robo.sv
// tb_controle_robo: scoreboard of expected output changes (cycle + value) checked by a negedge monitor
module tb_controle_robo;
  typedef struct {int cyc; logic [6:0] v;} exp_t;

  logic c1 = 1'b0, reset = 1'b0;
  logic [6:0] obs, prev;
  exp_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit mon_on = 1'b0;

  always #5 c1 = ~c1;
  always @(posedge c1) cyc <= cyc + 1;

  controle_robo_if bus();
  controle_robo dut (.c1(c1), .reset(reset), .bus(bus));

  assign obs = {bus.estado, bus.avancar, bus.girar, bus.remover, bus.falha};

  function automatic logic [6:0] pk(input logic [2:0] st, input logic f);
    return {st, st == 3'b000 || st == 3'b010, st == 3'b100, st == 3'b011, f};
  endfunction

  task automatic expect_at(input int dc, input logic [2:0] st, input logic f);
    exp_t e;
    e.cyc = cyc + dc;
    e.v = pk(st, f);
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge c1);
  endtask

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  initial forever begin
    @(negedge c1);
    if (mon_on && obs !== prev) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b", cyc, obs);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.v !== obs || e.cyc != cyc) begin
          n_bad++;
          $display("FAIL out_change got cyc=%0d val=%b required cyc=%0d val=%b", cyc, obs, e.cyc, e.v);
        end
      end
      prev = obs;
    end
  end

  initial begin
    {bus.habilita, bus.head, bus.left, bus.under, bus.barreira} = '0;
    #12;
    chk("reset_state", obs, pk(3'b111, 1'b0));
    @(negedge c1);
    reset = 1'b1;
    prev = obs;
    mon_on = 1'b1;
    step(2);
    // enable, then an exploratory turn after the search timeout
    bus.habilita = 1'b1;
    expect_at(3, 3'b000, 1'b0);
    expect_at(1027, 3'b100, 1'b0);
    expect_at(1043, 3'b000, 1'b0);
    step(1045);
    // short left glitch ignored, then held left starts following
    bus.left = 1'b1;
    step(3);
    bus.left = 1'b0;
    step(12);
    bus.left = 1'b1;
    expect_at(7, 3'b010, 1'b0);
    step(10);
    // head obstacle turn, released mid-turn, back to following
    bus.head = 1'b1;
    expect_at(7, 3'b100, 1'b0);
    step(8);
    bus.head = 1'b0;
    expect_at(15, 3'b010, 1'b0);
    step(18);
    // debris cleared during the first retry
    bus.barreira = 1'b1;
    expect_at(7, 3'b011, 1'b0);
    expect_at(23, 3'b010, 1'b0);
    step(10);
    bus.barreira = 1'b0;
    step(16);
    // stuck debris: three attempts then sticky fault
    bus.barreira = 1'b1;
    expect_at(7, 3'b011, 1'b0);
    expect_at(31, 3'b111, 1'b1);
    step(35);
    bus.barreira = 1'b0;
    step(10);
    bus.habilita = 1'b0;
    expect_at(3, 3'b111, 1'b0);
    step(5);
    bus.habilita = 1'b1;
    expect_at(3, 3'b000, 1'b0);
    expect_at(4, 3'b010, 1'b0);
    step(10);
    // cliff hazard during removal
    bus.barreira = 1'b1;
    expect_at(7, 3'b011, 1'b0);
    step(9);
    bus.under = 1'b1;
    expect_at(7, 3'b111, 1'b0);
    step(10);
    bus.under = 1'b0;
    bus.barreira = 1'b0;
    expect_at(7, 3'b000, 1'b0);
    expect_at(8, 3'b010, 1'b0);
    step(12);
    // asynchronous reset in the middle of a turn
    bus.head = 1'b1;
    expect_at(7, 3'b100, 1'b0);
    step(10);
    #2 reset = 1'b0;
    #1 chk("async_reset", obs, pk(3'b111, 1'b0));
    expect_at(1, 3'b111, 1'b0);
    @(negedge c1);
    @(negedge c1);
    reset = 1'b1;
    expect_at(3, 3'b000, 1'b0);
    expect_at(7, 3'b100, 1'b0);
    step(12);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_change required cyc=%0d val=%b got none", e.cyc, e.v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/controle_robo.md
# controle_robo

Parametrised wall-following controller for the cleaning robot, successor to the original sensor FSM. It synchronises and debounces the four robot sensors, then runs a registered-output state machine that searches for a wall, follows it, performs timed turns and timed debris removal with bounded retries, and reports a sticky fault. It sits between the raw sensor pins and the motor/arm drivers.

## Interface
- DEB_CYCLES, 4: consecutive stable synchronised samples before a filtered sensor changes (>=1)
- TURN_CYCLES, 16: cycles a GIRA turn lasts (>=1)
- REMOVE_CYCLES, 8: cycles one removal attempt lasts (>=1)
- SEARCH_MAX, 1024: cycles in PROCURA without wall contact before a forced exploratory turn (>=1)
- MAX_RETRY, 2: extra removal attempts after the first before declaring fault (>=0)
- c1  input  1  clock, rising edge
- reset  input  1  reset; one clock, asynchronous, active-low
- habilita  input  1  run enable (asynchronous; 2-FF synchronised, not debounced)
- head  input  1  front obstacle sensor (asynchronous, raw)
- left  input  1  left wall sensor (asynchronous, raw)
- under  input  1  floor/cliff sensor, 1 = hazard (asynchronous, raw)
- barreira  input  1  debris detector (asynchronous, raw)
- avancar  output  1  drive forward
- girar  output  1  rotate
- remover  output  1  removal arm active
- estado  output  3  current state code
- falha  output  1  sticky removal-failure flag

## Operation
- Sensor path, per sensor: 2-FF synchroniser, then filter. Filter counter clears when sync value equals filtered value; otherwise increments; on the edge where it would reach DEB_CYCLES the filtered value takes the sync value and the counter clears. Filtered values hd, lf, un, br reset to 0.
- State codes: STANDBY 3'b111, PROCURA 3'b000, ACOMPANHA 3'b010, REMOVE 3'b011, GIRA 3'b100. Anything else goes to STANDBY.
- Single counter cnt, a retry counter and search counter, sized by $clog2 of their parameter. cnt clears on every state entry.
- Global priority, checked first in every state: synchronised habilita=0 -> STANDBY. un=1 -> STANDBY.
- STANDBY: with habilita=1, un=0 and falha=0 -> PROCURA.
- PROCURA: br=1 -> REMOVE. Else hd=1 -> GIRA. Else lf=1 -> ACOMPANHA. Else when the search counter hits SEARCH_MAX-1 -> GIRA. Otherwise stay. The search counter clears on exit.
- ACOMPANHA: br=1 -> REMOVE. Else hd=1 -> GIRA. Else lf=0 -> PROCURA.
- GIRA: at cnt=TURN_CYCLES-1:
  - hd=1 -> restart turn (cnt=0).
  - Else lf=1 -> ACOMPANHA.
  - Else -> PROCURA.
- REMOVE: entry clears retry count. At cnt=REMOVE_CYCLES-1:
  - br=0 -> ACOMPANHA if lf, else PROCURA.
  - br=1 and retries<MAX_RETRY -> retries+1, restart.
  - br=1 and retries exhausted -> STANDBY with falha set.
- falha: set only as above. Cleared only while synchronised habilita=0.
- Outputs are Moore and registered, decoded from next state:
  - PROCURA / ACOMPANHA: avancar=1.
  - GIRA: girar=1.
  - REMOVE: remover=1.
  - STANDBY: all 0.
  - Never more than one of avancar/girar/remover high.

## Timing
- Reset asserted: all flops clear immediately. State STANDBY, estado=3'b111, avancar=girar=remover=0, falha=0, filters 0.
- Reset release is sampled on the first rising edge with reset=1.
- Raw sensor step held stable: filtered value changes on edge 2+DEB_CYCLES; state/outputs react on edge 3+DEB_CYCLES.
- A glitch shorter than DEB_CYCLES synchronised cycles is ignored.
- habilita: state reacts on the 3rd edge after a change.
- GIRA lasts exactly TURN_CYCLES cycles per attempt. REMOVE lasts exactly REMOVE_CYCLES cycles per attempt. Worst case REMOVE is (MAX_RETRY+1)*REMOVE_CYCLES cycles.
- Simultaneous events follow the stated priority order.
- Reset mid-turn or mid-removal aborts immediately with no completion pulse.

## Test plan
- Reset, then habilita=1 with all sensors 0 -> estado 3'b000 and avancar=1 on edge 3 after habilita. Hold 1024 cycles -> GIRA with girar=1 for exactly 16 cycles, then back to PROCURA.
- In PROCURA, left=1 held -> ACOMPANHA on edge 7 (DEB=4). A 3-cycle left pulse -> no transition.
- In ACOMPANHA, head=1 held -> GIRA. Release head during the turn -> after 16 cycles ACOMPANHA if left=1.
- barreira=1 for 10 cycles, then 0 -> REMOVE, remover=1 for 8 cycles (one retry, 16 total), then back to follow/search.
- barreira stuck 1 -> remover high 24 cycles, then STANDBY with falha=1. Stays there with habilita=1. habilita low then high -> falha clears, PROCURA.
- under=1 during REMOVE, and separately reset pulse during GIRA:
  - under -> STANDBY, all motor outputs 0.
  - reset -> outputs 0 asynchronously, estado=3'b111.
